// File: rtl/ram_2r1w_arbiter_if.sv
// Requester-side and RAM-helper-side bus of the 2r1w RAM arbiter.
// slave modport is the arbiter; master modport is the requesters plus RAM helper.
interface ram_2r1w_arbiter_if;
    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 64;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*DW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*DW-1:0] req_wmask;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ*DW-1:0] resp_rdata;

    logic               ram_en;
    logic [DW-1:0]      ram_ridx0;
    logic [DW-1:0]      ram_ridx1;
    logic [DW-1:0]      ram_rdata0;
    logic [DW-1:0]      ram_rdata1;
    logic [DW-1:0]      ram_widx;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_wmask;
    logic               ram_wen;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  ram_rdata0, ram_rdata1,
        output req_ready, resp_valid, resp_rdata,
        output ram_en, ram_ridx0, ram_ridx1, ram_widx, ram_wdata, ram_wmask, ram_wen
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output ram_rdata0, ram_rdata1,
        input  req_ready, resp_valid, resp_rdata,
        input  ram_en, ram_ridx0, ram_ridx1, ram_widx, ram_wdata, ram_wmask, ram_wen
    );
endinterface

// File: rtl/ram_2r1w_arbiter.sv
// Shares a 2-read/1-write RAM helper among three requesters with round-robin grants.
// Define RAM_ARB_WR_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_2r1w_arbiter #(
    parameter logic [63:0] BASE = 64'h8000_0000,
    parameter int unsigned NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_2r1w_arbiter_if.slave     bus
);
    localparam int unsigned DW = 64;
    localparam int unsigned PW = 2;

    logic [PW-1:0]      rd_ptr, rd_ptr_nxt;
    logic [PW-1:0]      wr_ptr, wr_ptr_nxt;
    logic [DW-1:0]      addr_a  [NREQ];
    logic [DW-1:0]      wdata_a [NREQ];
    logic [DW-1:0]      wmask_a [NREQ];
    logic [NREQ-1:0]    is_rd, is_wr, gnt;
    logic               rd_hit0, rd_hit1, wr_hit;
    logic [PW-1:0]      rd_id0, rd_id1, wr_id;
    logic [PW-1:0]      rd_cand, wr_cand;
    logic [DW-1:0]      ridx0, ridx1, widx, wdata_w, wmask_w;
    logic [DW-1:0]      rdata0, rdata1;
    logic [NREQ*DW-1:0] resp_rdata_nxt;

    // Modulo-NREQ pointer increment; both operands are always below NREQ.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW-1:0] k);
        logic [PW:0] s;
        s = (PW+1)'(p) + (PW+1)'(k);
        return (s >= (PW+1)'(NREQ)) ? PW'(s - (PW+1)'(NREQ)) : PW'(s);
    endfunction

    // Byte address to RAM word index; low three bits drop out of the shift.
    function automatic logic [DW-1:0] word_idx(input logic [DW-1:0] a);
        logic [DW-1:0] off;
        off = a - BASE;
        return off >> 3;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*DW +: DW];
        assign wdata_a[g] = bus.req_wdata[g*DW +: DW];
        assign wmask_a[g] = bus.req_wmask[g*DW +: DW];
    end

    assign is_rd = bus.req_valid & ~bus.req_wen;
    assign is_wr = bus.req_valid &  bus.req_wen;

    // Read scan from rd_ptr: first reader takes port 0, second takes port 1.
    always_comb begin
        rd_hit0 = 1'b0;
        rd_hit1 = 1'b0;
        rd_id0  = '0;
        rd_id1  = '0;
        rd_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            rd_cand = ptr_add(rd_ptr, PW'(k));
            if (rst_n && is_rd[rd_cand]) begin
                if (!rd_hit0) begin
                    rd_hit0 = 1'b1;
                    rd_id0  = rd_cand;
                end else if (!rd_hit1) begin
                    rd_hit1 = 1'b1;
                    rd_id1  = rd_cand;
                end
            end
        end
    end

    // Write scan from wr_ptr: first writer takes the write port.
    always_comb begin
        wr_hit  = 1'b0;
        wr_id   = '0;
        wr_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            wr_cand = ptr_add(wr_ptr, PW'(k));
            if (rst_n && is_wr[wr_cand] && !wr_hit) begin
                wr_hit = 1'b1;
                wr_id  = wr_cand;
            end
        end
    end

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (rd_hit1) begin
            rd_ptr_nxt = ptr_add(rd_id1, PW'(1));
        end else if (rd_hit0) begin
            rd_ptr_nxt = ptr_add(rd_id0, PW'(1));
        end
        wr_ptr_nxt = wr_ptr;
        if (wr_hit) begin
            wr_ptr_nxt = ptr_add(wr_id, PW'(1));
        end
    end

    always_comb begin
        gnt = '0;
        if (rd_hit0) gnt[rd_id0] = 1'b1;
        if (rd_hit1) gnt[rd_id1] = 1'b1;
        if (wr_hit)  gnt[wr_id]  = 1'b1;
    end

    assign ridx0   = rd_hit0 ? word_idx(addr_a[rd_id0]) : '0;
    assign ridx1   = rd_hit1 ? word_idx(addr_a[rd_id1]) : '0;
    assign widx    = wr_hit  ? word_idx(addr_a[wr_id])  : '0;
    assign wdata_w = wr_hit  ? wdata_a[wr_id] : '0;
    assign wmask_w = wr_hit  ? wmask_a[wr_id] : '0;

`ifdef RAM_ARB_WR_BYPASS_EN
    // Colliding read sees the merged post-write word.
    assign rdata0 = (wr_hit && rd_hit0 && (ridx0 == widx))
                  ? ((wdata_w & wmask_w) | (bus.ram_rdata0 & ~wmask_w)) : bus.ram_rdata0;
    assign rdata1 = (wr_hit && rd_hit1 && (ridx1 == widx))
                  ? ((wdata_w & wmask_w) | (bus.ram_rdata1 & ~wmask_w)) : bus.ram_rdata1;
`else
    assign rdata0 = bus.ram_rdata0;
    assign rdata1 = bus.ram_rdata1;
`endif

    // Route port data to the granted reader's response slot; writes return 0.
    always_comb begin
        resp_rdata_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_hit0 && (rd_id0 == PW'(i))) begin
                resp_rdata_nxt[i*DW +: DW] = rdata0;
            end else if (rd_hit1 && (rd_id1 == PW'(i))) begin
                resp_rdata_nxt[i*DW +: DW] = rdata1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= '0;
            bus.resp_rdata <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
        end else begin
            bus.resp_valid <= gnt;
            bus.resp_rdata <= resp_rdata_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_ptr         <= wr_ptr_nxt;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.ram_en    = rd_hit0 | wr_hit;
    assign bus.ram_ridx0 = ridx0;
    assign bus.ram_ridx1 = ridx1;
    assign bus.ram_wen   = wr_hit;
    assign bus.ram_widx  = widx;
    assign bus.ram_wdata = wdata_w;
    assign bus.ram_wmask = wmask_w;

endmodule

// File: tb/tb_ram_2r1w_arbiter.sv
// Directed and randomized check of ram_2r1w_arbiter against a queue-based
// arbitration model and a separate reference memory image.
module tb_ram_2r1w_arbiter;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_2r1w_arbiter_if ifc ();
    ram_2r1w_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // RAM helper: combinational reads, bit-masked write at the clock edge.
    logic [63:0] tb_mem [256] = '{default: '0};
    assign ifc.ram_rdata0 = tb_mem[ifc.ram_ridx0[7:0]];
    assign ifc.ram_rdata1 = tb_mem[ifc.ram_ridx1[7:0]];
    always @(posedge clk) begin
        if (ifc.ram_wen)
            tb_mem[ifc.ram_widx[7:0]] <= (ifc.ram_wdata & ifc.ram_wmask)
                                       | (tb_mem[ifc.ram_widx[7:0]] & ~ifc.ram_wmask);
    end

    // Pending requests, held until granted.
    logic [2:0]  p_valid, p_wen;
    logic [63:0] p_addr [3], p_wdata [3], p_wmask [3];

    // Reference model state and per-cycle expectations.
    logic [63:0] ref_mem [256] = '{default: '0};
    int          m_rd_ptr, m_wr_ptr, n_rd_ptr, n_wr_ptr, w_id;
    logic [2:0]  e_ready;
    logic        e_wen, e_en;
    logic [63:0] e_ridx0, e_ridx1, e_widx, e_wdata, e_wmask;
    logic [63:0] e_rdata [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] widx_of(input logic [63:0] a);
        return (a - BASE) / 8;
    endfunction

    task automatic drive();
        ifc.req_valid = p_valid;
        ifc.req_wen   = p_wen;
        for (int i = 0; i < 3; i++) begin
            ifc.req_addr[i*64 +: 64]  = p_addr[i];
            ifc.req_wdata[i*64 +: 64] = p_wdata[i];
            ifc.req_wmask[i*64 +: 64] = p_wmask[i];
        end
    endtask

    // Build the rotated reader list and pick the first writer.
    task automatic model_comb();
        int q[$];
        int id;
        logic [63:0] idx, old;
        e_ready = '0; e_ridx0 = '0; e_ridx1 = '0;
        e_wen = 1'b0; e_widx = '0; e_wdata = '0; e_wmask = '0;
        for (int i = 0; i < 3; i++) e_rdata[i] = '0;
        w_id = -1;
        for (int k = 0; k < 3; k++) begin
            id = (m_rd_ptr + k) % 3;
            if (p_valid[id] && !p_wen[id]) q.push_back(id);
        end
        for (int k = 0; k < 3; k++) begin
            id = (m_wr_ptr + k) % 3;
            if (w_id < 0 && p_valid[id] && p_wen[id]) w_id = id;
        end
        if (w_id >= 0) begin
            e_wen = 1'b1; e_ready[w_id] = 1'b1;
            e_widx = widx_of(p_addr[w_id]); e_wdata = p_wdata[w_id]; e_wmask = p_wmask[w_id];
        end
        for (int j = 0; j < 2 && j < q.size(); j++) begin
            id  = q[j];
            idx = widx_of(p_addr[id]);
            e_ready[id] = 1'b1;
            if (j == 0) e_ridx0 = idx; else e_ridx1 = idx;
            old = ref_mem[idx[7:0]];
`ifdef RAM_ARB_WR_BYPASS_EN
            if (e_wen && idx == e_widx) old = (e_wdata & e_wmask) | (old & ~e_wmask);
`endif
            e_rdata[id] = old;
        end
        n_rd_ptr = (q.size() == 0) ? m_rd_ptr : (q[(q.size() > 1) ? 1 : 0] + 1) % 3;
        n_wr_ptr = (w_id < 0) ? m_wr_ptr : (w_id + 1) % 3;
        e_en = (e_ready != 3'b000);
    endtask

    task automatic model_commit();
        if (e_wen)
            ref_mem[e_widx[7:0]] = (e_wdata & e_wmask) | (ref_mem[e_widx[7:0]] & ~e_wmask);
        m_rd_ptr = n_rd_ptr;
        m_wr_ptr = n_wr_ptr;
        p_valid  = p_valid & ~e_ready;
    endtask

    // One clock: check grant/port drive, then the registered responses.
    task automatic cycle();
        drive();
        #1;
        model_comb();
        chk("req_ready", 64'(ifc.req_ready), 64'(e_ready));
        chk("ram_en",    64'(ifc.ram_en),    64'(e_en));
        chk("ram_ridx0", ifc.ram_ridx0, e_ridx0);
        chk("ram_ridx1", ifc.ram_ridx1, e_ridx1);
        chk("ram_wen",   64'(ifc.ram_wen),   64'(e_wen));
        chk("ram_widx",  ifc.ram_widx,  e_widx);
        chk("ram_wdata", ifc.ram_wdata, e_wdata);
        chk("ram_wmask", ifc.ram_wmask, e_wmask);
        @(posedge clk);
        #1;
        chk("resp_valid", 64'(ifc.resp_valid), 64'(e_ready));
        for (int i = 0; i < 3; i++)
            chk($sformatf("resp_rdata%0d", i), ifc.resp_rdata[i*64 +: 64], e_rdata[i]);
        model_commit();
    endtask

    task automatic set_req(input int i, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] wmask);
        p_valid[i] = 1'b1; p_wen[i] = wen; p_addr[i] = addr;
        p_wdata[i] = wdata; p_wmask[i] = wmask;
    endtask

    initial begin
        int          win [4];
        logic [63:0] msk [3];
        logic [63:0] exp_v;
        win = '{0, 1, 2, 0};
        msk = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00};
        m_rd_ptr = 0; m_wr_ptr = 0;
        p_valid = '0; p_wen = '0;
        for (int i = 0; i < 3; i++) begin p_addr[i] = BASE; p_wdata[i] = '0; p_wmask[i] = '0; end

        // Reset with every requester asking.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, BASE + 64'(i*8), '0, '0);
        drive();
        #12;
        chk("rst_ready",      64'(ifc.req_ready),  64'd0);
        chk("rst_ram_en",     64'(ifc.ram_en),     64'd0);
        chk("rst_ram_wen",    64'(ifc.ram_wen),    64'd0);
        chk("rst_resp_valid", 64'(ifc.resp_valid), 64'd0);
        p_valid = '0;
        drive();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Write contention from wr_ptr = 0: winners 0,1,2,0.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 3; i++)
                set_req(i, 1'b1, BASE + 64'(i*8), 64'h1111_0000 * 64'(i+1) + 64'(c), msk[i]);
            drive(); #1;
            chk("wc_ready", 64'(ifc.req_ready), 64'(3'b001 << win[c]));
            chk("wc_widx",  ifc.ram_widx,  64'(win[c]));
            chk("wc_wmask", ifc.ram_wmask, msk[win[c]]);
            cycle();
        end
        p_valid = '0;

        // Three concurrent reads with rd_ptr = 0.
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, BASE + 64'(i*8), '0, '0);
        drive(); #1;
        chk("r3_ready0", 64'(ifc.req_ready), 64'(3'b011));
        chk("r3_ridx0",  ifc.ram_ridx0, 64'd0);
        chk("r3_ridx1",  ifc.ram_ridx1, 64'd1);
        cycle();
        drive(); #1;
        chk("r3_ready1", 64'(ifc.req_ready), 64'(3'b100));
        cycle();

        // Same-cycle write/read on word 8.
        set_req(2, 1'b1, BASE + 64'h40, 64'h1234, '1);
        cycle();
        set_req(0, 1'b1, BASE + 64'h40, 64'hDEAD, '1);
        set_req(1, 1'b0, BASE + 64'h43, '0, '0);
        cycle();
`ifdef RAM_ARB_WR_BYPASS_EN
        exp_v = 64'hDEAD;
`else
        exp_v = 64'h1234;
`endif
        chk("mix_collide", ifc.resp_rdata[127:64], exp_v);
        set_req(1, 1'b0, BASE + 64'h40, '0, '0);
        cycle();
        chk("mix_after", ifc.resp_rdata[127:64], 64'hDEAD);

        // Partial mask over a zero word.
        set_req(0, 1'b1, BASE + 64'h80, 64'd0, '1);
        cycle();
        set_req(0, 1'b1, BASE + 64'h80, '1, 64'h0000_0000_FFFF_FFFF);
        cycle();
        set_req(1, 1'b0, BASE + 64'h80, '0, '0);
        cycle();
        chk("pmask", ifc.resp_rdata[127:64], 64'h0000_0000_FFFF_FFFF);

        // Reset right after a read grant.
        set_req(2, 1'b0, BASE, '0, '0);
        drive(); #1;
        model_comb();
        @(posedge clk); #1;
        chk("mid_resp_before", 64'(ifc.resp_valid), 64'(3'b100));
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, BASE, '0, '0);
        drive();
        #1;
        chk("mid_resp_drop",  64'(ifc.resp_valid), 64'd0);
        chk("mid_rdata_drop", ifc.resp_rdata[191:128], 64'd0);
        chk("mid_ready",      64'(ifc.req_ready), 64'd0);
        chk("mid_ram_en",     64'(ifc.ram_en),    64'd0);
        m_rd_ptr = 0; m_wr_ptr = 0; p_valid = '0;
        drive();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle();

        // Randomized traffic over 16 words, byte offsets included.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!p_valid[i] && $urandom_range(99) < 70) begin
                    case ($urandom_range(2))
                        0:       exp_v = '1;
                        1:       exp_v = 64'h0000_0000_FFFF_FFFF;
                        default: exp_v = {$urandom, $urandom};
                    endcase
                    set_req(i, 1'($urandom_range(1)),
                            BASE + 64'($urandom_range(15) * 8) + 64'($urandom_range(7)),
                            {$urandom, $urandom}, exp_v);
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_2r1w_arbiter.md
# ram_2r1w_arbiter

Shares one two-read/one-write simulation RAM between three requesters (instruction fetch, load/store unit, DMA) in the difftest SoC model. Each cycle it grants up to two reads and one write with independent round-robin pointers, drives the RAM helper's read indices, write index, write data, mask and enables, and returns registered read data with one-cycle latency. It sits between the core/DMA memory ports and the 2r1w RAM helper.

## Interface
- `BASE`, 64'h8000_0000, byte address mapped to RAM word index 0
- `NREQ`, 3, number of requesters (fixed at 3; the indices below assume it)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  3  request valid per requester i
- `req_ready`  out  3  grant; the request completes when valid & ready
- `req_wen`  in  3  1 = write, 0 = read
- `req_addr`  in  3x64  byte address; slice i is [64i+63:64i]
- `req_wdata`  in  3x64  write data
- `req_wmask`  in  3x64  bit-level write mask
- `resp_valid`  out  3  one-cycle pulse for the completed request
- `resp_rdata`  out  3x64  read data; 0 for writes
- `ram_en`  out  1  RAM helper enable
- `ram_ridx0`, `ram_ridx1`  out  64  read word indices
- `ram_rdata0`, `ram_rdata1`  in  64  combinational read data from the RAM helper
- `ram_widx`, `ram_wdata`, `ram_wmask`  out  64  write index, data and mask
- `ram_wen`  out  1  write enable

## Operation
- Word index: `(req_addr - BASE) >> 3`, a 64-bit modular subtraction. Byte offset bits [2:0] are ignored.
- Read arbitration (combinational):
  - Scan readers (valid & !wen) in order `rd_ptr, rd_ptr+1, rd_ptr+2` (mod 3).
  - The first reader found gets port 0; the second gets port 1; any third waits.
- Read pointer: on any read grant, the registered `rd_ptr` moves to one past the last granted reader (mod 3). With no read grant it holds.
- Write arbitration:
  - Writers (valid & wen) are scanned from `wr_ptr`; the first one found gets the write port.
  - On a write grant, `wr_ptr` moves to the winner + 1 (mod 3).
- Grant handshake:
  - `req_ready[i]` is combinational, high only in the cycle requester i is granted.
  - Granting does not depend on `req_ready`, so there is no combinational loop.
  - Requesters hold their request stable until granted.
- Port drive: `ram_en` = any grant. An unused read port index is driven to 0. With no write grant, `ram_wen` = 0 and `ram_widx`/`ram_wdata`/`ram_wmask` = 0.
- Response: on the clock edge of a grant, set `resp_valid[i]` and capture `resp_rdata[i]` (port data for a read, 0 for a write). Both clear the next cycle unless i is granted again. Requesters always accept responses.
- Back-to-back: one requester may be granted on consecutive cycles.
- Same-index read/write collision: the read returns the pre-write data (read-before-write), unless bypass is compiled in (see Configuration).

## Timing
- Reset (async assert, sync release):
  - `resp_valid` = 0, `resp_rdata` = 0, `rd_ptr` = 0, `wr_ptr` = 0.
  - `req_ready`, `ram_en`, `ram_wen` forced to 0 while `rst_n` is low.
- Latency: grant in cycle N; `resp_valid`/`resp_rdata` at cycle N+1. The RAM write takes effect at the end of cycle N.
- Throughput: 2 reads + 1 write per cycle.
- Reset mid-operation: responses pending in the registers are discarded; no response is issued for grants taken in the cycle reset asserts.

## Configuration
- `RAM_ARB_WR_BYPASS_EN` defined:
  - Applies when a granted read has the same word index as the granted write in the same cycle.
  - Captured data = `(wdata & wmask) | (ram_rdata & ~wmask)`, i.e. read-after-write.
- Undefined: captured data = raw `ram_rdata` (old data); no bypass logic is built.

## Test plan
- Reset: hold `rst_n` = 0 with all `req_valid` = 3'b111 → `req_ready` = 0, `ram_en` = 0, `resp_valid` = 0. Release → the first grants follow `rd_ptr` = `wr_ptr` = 0.
- Three concurrent reads: addresses 0x8000_0000, 0x8000_0008, 0x8000_0010 with pointer 0 →
  - Cycle 0: readers 0 and 1 granted, `ram_ridx0` = 0, `ram_ridx1` = 1.
  - Cycle 1: reader 2 granted.
  - Responses arrive one cycle after each grant.
- Write contention: all three write for 4 cycles → winners 0, 1, 2, 0, with `ram_widx`/`ram_wmask` matching each winner.
- Mixed ops: req0 writes 0xDEAD to 0x8000_0040 with mask all-ones while req1 reads 0x8000_0040 in the same cycle →
  - Without the macro: `resp_rdata[1]` = old value.
  - With `RAM_ARB_WR_BYPASS_EN`: 0xDEAD.
  - Subsequent read: 0xDEAD in both builds.
- Partial mask: write 0xFFFF_FFFF_FFFF_FFFF with mask 0x0000_0000_FFFF_FFFF over 0 → readback 0x0000_0000_FFFF_FFFF.
- Reset mid-flight: assert `rst_n` low in the cycle after a read grant → `resp_valid` drops to 0 immediately, and no stale response appears after release.
